// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmit FSM states, completion codes, command bytes
// and the frame parity helper used by both the transmit and receive paths.
`timescale 1ns/1ps
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_INHIBIT   = 3'd1,
    ST_START     = 3'd2,
    ST_BITS      = 3'd3,
    ST_ACK       = 3'd4,
    ST_WAIT_IDLE = 3'd5,
    ST_DONE      = 3'd6
  } tx_state_e;

  localparam logic [1:0] ERR_OK        = 2'b00;
  localparam logic [1:0] ERR_NO_ACK    = 2'b01;
  localparam logic [1:0] ERR_FIRST_CLK = 2'b10;
  localparam logic [1:0] ERR_BIT_TMO   = 2'b11;

  localparam logic [7:0] CMD_ENABLE = 8'hF4;
  localparam logic [7:0] CMD_RESET  = 8'hFF;
  localparam logic [7:0] RSP_ACK    = 8'hFA;

  // PS/2 frames carry odd parity over the eight data bits
  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer plus stability filter for a PS/2 pad; emits a one-cycle
// pulse when the filtered level falls from 1 to 0.
`timescale 1ns/1ps
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic line_in,
  output logic line_sync,
  output logic fall
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN + 1) : 1;

  logic [1:0]    sync_r;
  logic          filt_r;
  logic          fall_r;
  logic [CW-1:0] cnt_r;
  logic          stable_s;

  assign stable_s  = (cnt_r == CW'(FILTER_LEN - 1));
  assign line_sync = sync_r[1];
  assign fall      = fall_r;

  // Synchronize, then accept a new level only after FILTER_LEN consecutive differing samples
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_r <= 2'b11;
      filt_r <= 1'b1;
      fall_r <= 1'b0;
      cnt_r  <= {CW{1'b0}};
    end else begin
      sync_r <= {sync_r[0], line_in};
      fall_r <= 1'b0;
      if (sync_r[1] == filt_r) begin
        cnt_r <= {CW{1'b0}};
      end else if (stable_s) begin
        filt_r <= sync_r[1];
        fall_r <= filt_r;
        cnt_r  <= {CW{1'b0}};
      end else begin
        cnt_r <= cnt_r + CW'(1);
      end
    end
  end

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, issues request-to-send and
// shifts one command byte out on device-generated clocks, then checks the ACK.
`timescale 1ns/1ps
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES    = 12_000,
  parameter int START_HOLD        = 200,
  parameter int FIRST_CLK_TIMEOUT = 1_500_000,
  parameter int BIT_TIMEOUT       = 20_000,
  parameter int FILTER_LEN        = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_err,
  output logic [1:0] err_code,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int MAX_AB = (INHIBIT_CYCLES > START_HOLD) ? INHIBIT_CYCLES : START_HOLD;
  localparam int MAX_CD = (FIRST_CLK_TIMEOUT > BIT_TIMEOUT) ? FIRST_CLK_TIMEOUT : BIT_TIMEOUT;
  localparam int MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CNT_W = $clog2(MAX_CYC + 1);

  tx_state_e    state_r, state_s;
  logic [CNT_W-1:0] cnt_r;
  logic [3:0]   bit_cnt_r, bit_cnt_s;
  logic [8:0]   shift_r;
  logic         drv_r, drv_s;
  logic [1:0]   err_pend_r, err_pend_s;
  logic [1:0]   data_sync_r;
  logic         accept_s, cnt_clr_s;
  logic         clk_oe_s, data_oe_s;
  logic         clk_sync_s, clk_fall_s, data_sync_s;
  logic         inhibit_hit_s, start_hit_s, first_hit_s, bit_hit_s, tmo_s;
  logic         clk_oe_r, data_oe_r, tx_ready_r, busy_r, tx_done_r, tx_err_r;
  logic [1:0]   err_code_r;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk       (clk),
    .rst       (rst),
    .line_in   (ps2_clk_in),
    .line_sync (clk_sync_s),
    .fall      (clk_fall_s)
  );

  assign data_sync_s   = data_sync_r[1];
  assign inhibit_hit_s = (cnt_r == CNT_W'(INHIBIT_CYCLES - 1));
  assign start_hit_s   = (cnt_r == CNT_W'(START_HOLD - 1));
  assign first_hit_s   = (cnt_r == CNT_W'(FIRST_CLK_TIMEOUT - 1));
  assign bit_hit_s     = (cnt_r == CNT_W'(BIT_TIMEOUT - 1));
  assign tmo_s         = (bit_cnt_r == 4'd0) ? first_hit_s : bit_hit_s;

  assign ps2_clk_oe  = clk_oe_r;
  assign ps2_data_oe = data_oe_r;
  assign tx_ready    = tx_ready_r;
  assign busy        = busy_r;
  assign tx_done     = tx_done_r;
  assign tx_err      = tx_err_r;
  assign err_code    = err_code_r;

  // Next-state, frame bit selection and line-drive decode
  always_comb begin
    state_s    = state_r;
    bit_cnt_s  = bit_cnt_r;
    drv_s      = drv_r;
    err_pend_s = err_pend_r;
    accept_s   = 1'b0;
    cnt_clr_s  = 1'b0;
    clk_oe_s   = 1'b0;
    data_oe_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (tx_valid) begin
          state_s    = ST_INHIBIT;
          accept_s   = 1'b1;
          err_pend_s = ERR_OK;
          bit_cnt_s  = 4'd0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_INHIBIT: begin
        if (inhibit_hit_s) state_s = ST_START;
        else               state_s = ST_INHIBIT;
      end
      ST_START: begin
        if (start_hit_s) begin
          state_s   = ST_BITS;
          drv_s     = 1'b1;
          bit_cnt_s = 4'd0;
        end else begin
          state_s = ST_START;
        end
      end
      ST_BITS: begin
        // Bits 0..7 are data, 8 is parity; fall #10 releases the line as the stop bit
        if (clk_fall_s) begin
          cnt_clr_s = 1'b1;
          if (bit_cnt_r <= 4'd8) begin
            drv_s     = ~shift_r[bit_cnt_r];
            bit_cnt_s = bit_cnt_r + 4'd1;
          end else begin
            drv_s     = 1'b0;
            bit_cnt_s = 4'd10;
            state_s   = ST_ACK;
          end
        end else if (tmo_s) begin
          state_s    = ST_DONE;
          drv_s      = 1'b0;
          err_pend_s = (bit_cnt_r == 4'd0) ? ERR_FIRST_CLK : ERR_BIT_TMO;
        end else begin
          state_s = ST_BITS;
        end
      end
      ST_ACK: begin
        if (clk_fall_s) begin
          cnt_clr_s  = 1'b1;
          err_pend_s = data_sync_s ? ERR_NO_ACK : ERR_OK;
          state_s    = ST_WAIT_IDLE;
        end else if (bit_hit_s) begin
          state_s    = ST_DONE;
          err_pend_s = ERR_BIT_TMO;
        end else begin
          state_s = ST_ACK;
        end
      end
      ST_WAIT_IDLE: begin
        if (clk_sync_s && data_sync_s) begin
          state_s = ST_DONE;
        end else if (bit_hit_s) begin
          state_s    = ST_DONE;
          err_pend_s = ERR_BIT_TMO;
        end else begin
          state_s = ST_WAIT_IDLE;
        end
      end
      ST_DONE: state_s = ST_IDLE;
      default: begin
        state_s = ST_IDLE;
        drv_s   = 1'b0;
      end
    endcase

    if (state_s != state_r) cnt_clr_s = 1'b1;
    else                    cnt_clr_s = cnt_clr_s;

    // Line drives follow the next state so timeouts release both lines on entry to DONE
    case (state_s)
      ST_INHIBIT: clk_oe_s = 1'b1;
      ST_START: begin
        clk_oe_s  = 1'b1;
        data_oe_s = 1'b1;
      end
      ST_BITS: data_oe_s = drv_s;
      default: begin
        clk_oe_s  = 1'b0;
        data_oe_s = 1'b0;
      end
    endcase
  end

  // State, counters, frame register and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      cnt_r       <= {CNT_W{1'b0}};
      bit_cnt_r   <= 4'd0;
      shift_r     <= 9'd0;
      drv_r       <= 1'b0;
      err_pend_r  <= ERR_OK;
      data_sync_r <= 2'b11;
      clk_oe_r    <= 1'b0;
      data_oe_r   <= 1'b0;
      tx_ready_r  <= 1'b1;
      busy_r      <= 1'b0;
      tx_done_r   <= 1'b0;
      tx_err_r    <= 1'b0;
      err_code_r  <= ERR_OK;
    end else begin
      state_r     <= state_s;
      bit_cnt_r   <= bit_cnt_s;
      drv_r       <= drv_s;
      err_pend_r  <= err_pend_s;
      data_sync_r <= {data_sync_r[0], ps2_data_in};
      clk_oe_r    <= clk_oe_s;
      data_oe_r   <= data_oe_s;
      tx_ready_r  <= (state_s == ST_IDLE);
      busy_r      <= (state_s != ST_IDLE);
      tx_done_r   <= (state_s == ST_DONE);
      if (cnt_clr_s) begin
        cnt_r <= {CNT_W{1'b0}};
      end else if (cnt_r != {CNT_W{1'b1}}) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end else begin
        cnt_r <= cnt_r;
      end
      if (accept_s) begin
        shift_r <= {odd_parity(tx_data), tx_data};
      end else begin
        shift_r <= shift_r;
      end
      if (state_s == ST_DONE) begin
        tx_err_r   <= (err_pend_s != ERR_OK);
        err_code_r <= err_pend_s;
      end else begin
        tx_err_r   <= tx_err_r;
        err_code_r <= err_code_r;
      end
    end
  end

endmodule
